// File: rtl/memory_loader.sv
// Byte-stream loader: parses a 3-byte header (start, length) and writes the payload bytes
// into the parameter memory write port, one registered write per accepted byte.
module memory_loader #(
    parameter int unsigned DEPTH = 320,
    parameter int unsigned AW    = 9,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          abort,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_we,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW:0]   bytes_written
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr1,
        StHdr2,
        StCheck,
        StWrite,
        StFinish
    } state_e;

    localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

    state_e        state_q;
    logic          in_ready_q;
    logic [AW-1:0] start_q;
    logic [AW-1:0] len_q;
    logic [AW-1:0] ptr_q;
    logic [AW:0]   cnt_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_data_q;
    logic          mem_we_q;
    logic          done_q;
    logic          error_q;
    logic [AW:0]   bw_q;

    logic          accept;
    logic [AW:0]   len_total;
    logic [AW:0]   end_excl;
    logic          range_bad;

    // in_ready_q is only ever 1 in accepting states, so it alone qualifies a transfer.
    assign accept    = in_valid && in_ready_q;
    assign len_total = {1'b0, len_q} + 1'b1;
    assign end_excl  = {1'b0, start_q} + len_total;
    assign range_bad = ({1'b0, start_q} >= DepthW) || (end_excl > DepthW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            in_ready_q <= 1'b0;
            start_q    <= '0;
            len_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            bw_q       <= '0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            if (abort) begin
                state_q    <= StIdle;
                in_ready_q <= 1'b1;
            end else begin
                case (state_q)
                    StIdle: begin
                        in_ready_q <= 1'b1;
                        if (accept && in_data[DW-1]) begin
                            start_q <= {in_data[0], {(AW-1){1'b0}}};
                            len_q   <= {in_data[1], {(AW-1){1'b0}}};
                            error_q <= 1'b0;
                            bw_q    <= '0;
                            state_q <= StHdr1;
                        end
                    end
                    StHdr1: begin
                        if (accept) begin
                            start_q <= {start_q[AW-1], in_data};
                            state_q <= StHdr2;
                        end
                    end
                    StHdr2: begin
                        if (accept) begin
                            len_q      <= {len_q[AW-1], in_data};
                            state_q    <= StCheck;
                            in_ready_q <= 1'b0;
                        end
                    end
                    StCheck: begin
                        in_ready_q <= 1'b1;
                        if (range_bad) begin
                            error_q <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            ptr_q   <= start_q;
                            cnt_q   <= len_total;
                            state_q <= StWrite;
                        end
                    end
                    StWrite: begin
                        if (accept) begin
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= ptr_q;
                            mem_data_q <= in_data;
                            ptr_q      <= ptr_q + 1'b1;
                            bw_q       <= bw_q + 1'b1;
                            cnt_q      <= cnt_q - 1'b1;
                            if (cnt_q == (AW+1)'(1)) begin
                                // done coincides with the final write in FINISH
                                done_q     <= 1'b1;
                                in_ready_q <= 1'b0;
                                state_q    <= StFinish;
                            end
                        end
                    end
                    StFinish: begin
                        in_ready_q <= 1'b1;
                        state_q    <= StIdle;
                    end
                    default: begin
                        in_ready_q <= 1'b1;
                        state_q    <= StIdle;
                    end
                endcase
            end
        end
    end

    assign in_ready      = in_ready_q;
    assign mem_addr      = mem_addr_q;
    assign mem_data      = mem_data_q;
    assign mem_we        = mem_we_q;
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign error         = error_q;
    assign bytes_written = bw_q;

endmodule

// File: tb/tb_memory_loader.sv
// Self-checking bench for memory_loader: table of header commands plus directed
// junk/abort/reset sequences, with a write scoreboard checked on every mem_we.
module tb_memory_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       abort = 1'b0;
    logic [8:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_we;
    logic       busy;
    logic       done;
    logic       error;
    logic [9:0] bytes_written;

    memory_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .abort        (abort),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_we       (mem_we),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .bytes_written(bytes_written)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    typedef struct {
        logic [8:0] addr;
        logic [7:0] data;
        int         acc_cyc;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] c2;
        logic       exp_err;
        bit         gaps;
    } cmd_t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Write scoreboard: every mem_we must match the oldest accepted payload byte, one cycle later.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (mem_we === 1'b1) begin
                wr_t e;
                wr_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_we: got write addr %0d with no pending byte", mem_addr);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", mem_addr, e.addr);
                    check("wr_data", mem_data, e.data);
                    check("wr_latency", cyc - e.acc_cyc, 1);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                check("done_with_we", mem_we, 1);
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input bit pay, input logic [8:0] addr);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got %0b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        if (pay) sb.push_back('{addr, b, cyc});
        @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
        send_byte(c0, 1'b0, '0);
        send_byte(c1, 1'b0, '0);
        send_byte(c2, 1'b0, '0);
        in_valid = 1'b0;
    endtask

    task automatic run_cmd(input cmd_t c);
        logic [8:0] st;
        int         len;
        int         d0;
        int         w0;
        st  = {c.c0[0], c.c1};
        len = {c.c0[1], c.c2} + 1;
        d0  = done_cnt;
        w0  = wr_cnt;
        send_hdr(c.c0, c.c1, c.c2);
        check("check_busy", busy, 1);
        check("check_in_ready", in_ready, 0);
        @(negedge clk);
        check("error", error, c.exp_err);
        check("busy_after_check", busy, !c.exp_err);
        if (c.exp_err) begin
            check("err_no_writes", wr_cnt - w0, 0);
            check("err_bytes_written", bytes_written, 0);
            return;
        end
        for (int i = 0; i < len; i++) begin
            if (c.gaps && $urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
            send_byte(8'((i * 37) + c.c1 + 8'h5A), 1'b1, 9'(st + i));
        end
        in_valid = 1'b0;
        check("done_pulse", done, 1);
        check("busy_in_finish", busy, 1);
        check("last_addr", mem_addr, 9'(st + len - 1));
        @(negedge clk);
        check("busy_fall", busy, 0);
        check("done_once", done_cnt - d0, 1);
        check("write_count", wr_cnt - w0, len);
        check("bytes_written", bytes_written, len);
        check("sb_empty", sb.size(), 0);
    endtask

    cmd_t tbl[7];

    initial begin
        int w0;
        int d0;
        tbl[0] = '{8'h80, 8'h00, 8'h03, 1'b0, 1'b0};  // basic 0..3
        tbl[1] = '{8'h81, 8'h3C, 8'h03, 1'b0, 1'b0};  // 316..319
        tbl[2] = '{8'h81, 8'h3C, 8'h04, 1'b1, 1'b0};  // one past the end
        tbl[3] = '{8'h80, 8'h05, 8'h09, 1'b0, 1'b1};  // 10 bytes with gaps
        tbl[4] = '{8'h83, 8'h00, 8'hFF, 1'b1, 1'b0};  // L=512
        tbl[5] = '{8'h81, 8'h40, 8'h00, 1'b1, 1'b0};  // start=320
        tbl[6] = '{8'h80, 8'h00, 8'h00, 1'b0, 1'b1};  // single byte

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_bw", bytes_written, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_data, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);

        w0 = wr_cnt;
        send_byte(8'h12, 1'b0, '0);
        in_valid = 1'b0;
        check("junk_busy", busy, 0);
        check("junk_ready", in_ready, 1);
        check("junk_no_write", wr_cnt - w0, 0);

        for (int i = 0; i < 7; i++) run_cmd(tbl[i]);

        // Abort after two payload bytes of a five-byte load
        w0 = wr_cnt;
        d0 = done_cnt;
        send_hdr(8'h80, 8'h10, 8'h04);
        @(negedge clk);
        send_byte(8'h11, 1'b1, 9'd16);
        send_byte(8'h22, 1'b1, 9'd17);
        check("abort_cycle_we", mem_we, 1);
        abort    = 1'b1;
        in_data  = 8'h33;
        in_valid = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", in_ready, 1);
        check("abort_bw", bytes_written, 2);
        check("abort_we_off", mem_we, 0);
        @(negedge clk);
        check("abort_writes", wr_cnt - w0, 2);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_sb_empty", sb.size(), 0);

        // Async reset in the middle of a write burst
        send_hdr(8'h80, 8'h20, 8'h07);
        @(negedge clk);
        send_byte(8'h01, 1'b1, 9'd32);
        send_byte(8'h02, 1'b1, 9'd33);
        send_byte(8'h03, 1'b1, 9'd34);
        check("pre_rst_we", mem_we, 1);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_we", mem_we, 0);
        check("async_busy", busy, 0);
        check("async_ready", in_ready, 0);
        check("async_bw", bytes_written, 0);
        sb.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst2", in_ready, 1);
        check("idle_after_rst2", busy, 0);
        run_cmd('{8'h80, 8'h00, 8'h03, 1'b0, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
